// File: rtl/cus19_dm_rd_ctrl_pkg.sv
// Shared definitions for the Custom-19 data-memory read path:
// addressing-mode opcodes and the read-controller state encoding.
package cus19_pkg;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_RIND = 3'b100;
    localparam logic [2:0] OP_IDX  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } rd_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_RIND) || (op == OP_IDX);
    endfunction

endpackage

// File: rtl/cus19_dm_rd_ctrl_if.sv
// Data-memory read port shared with the crypto accelerator.
// The read controller is the master; the memory/arbiter side is the slave.
interface cus19_dm_rd_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 19
);
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_gnt;
    logic              mem_rd_dvalid;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_gnt,
        input  mem_rd_dvalid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_gnt,
        output mem_rd_dvalid,
        output mem_rd_data
    );
endinterface

// File: rtl/cus19_dm_rd_ctrl_addr_gen.sv
// Combinational effective-address generator: selects LOAD, register-indirect
// or indexed addressing and flags opcodes that map to no addressing mode.
module cus19_dm_addr_gen
    import cus19_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int REG_W  = 8
) (
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] imm_addr,
    input  logic [REG_W-1:0]  rs2_data,
    output logic [ADDR_W-1:0] addr,
    output logic              legal
);
    logic [ADDR_W-1:0] rs2_ext;

    assign rs2_ext = ADDR_W'(rs2_data);

    // Indexed sum is kept at ADDR_W bits so it wraps around the memory.
    always_comb begin
        addr  = '0;
        legal = op_is_legal(opcode);
        case (opcode)
            OP_LOAD: addr = imm_addr;
            OP_RIND: addr = rs2_ext;
            OP_IDX:  addr = imm_addr + rs2_ext;
            default: addr = '0;
        endcase
    end
endmodule

// File: rtl/cus19_dm_rd_ctrl.sv
// Data-memory read controller: accepts a core read, issues it to the shared
// memory port with req/gnt, waits for data with a timeout and returns it.
module cus19_dm_rd_ctrl
    import cus19_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int REG_W   = 8,
    parameter int DATA_W  = 19,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_valid_in,
    output logic               rd_ready,
    input  logic [2:0]         opcode_in,
    input  logic [ADDR_W-1:0]  imm_addr_in,
    input  logic [REG_W-1:0]   rs2_data_in,
    cus19_dm_rd_ctrl_if.master mem,
    output logic [DATA_W-1:0]  rd_data_out,
    output logic               rd_data_valid,
    output logic               rd_err,
    output logic               stall_out
);
    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_eff;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              op_legal;
    logic              req_c;
    logic              accept_ok;
    logic              accept_bad;
    logic              capture;
    logic              timeout_hit;
    logic              cnt_run;

    cus19_dm_addr_gen #(
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W)
    ) u_addr_gen (
        .opcode   (opcode_in),
        .imm_addr (imm_addr_in),
        .rs2_data (rs2_data_in),
        .addr     (addr_eff),
        .legal    (op_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // dvalid is tested before the timeout so a same-cycle response wins.
    always_comb begin
        state_nxt     = state;
        rd_ready      = 1'b0;
        req_c         = 1'b0;
        rd_data_valid = 1'b0;
        accept_ok     = 1'b0;
        accept_bad    = 1'b0;
        capture       = 1'b0;
        timeout_hit   = 1'b0;
        cnt_run       = 1'b0;
        case (state)
            IDLE: begin
                rd_ready = rst_n;
                if (rd_valid_in && rd_ready) begin
                    if (op_legal) begin
                        accept_ok = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        accept_bad = 1'b1;
                    end
                end
            end
            ISSUE: begin
                req_c = 1'b1;
                if (mem.mem_rd_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rd_dvalid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            RESP: begin
                rd_data_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter sits at 0 outside WAIT, so every WAIT entry starts from 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= cnt_run ? (wait_cnt + CNT_W'(1)) : '0;
            err_q    <= accept_bad | timeout_hit;
            if (accept_ok) begin
                addr_q <= addr_eff;
            end
            if (capture) begin
                data_q <= mem.mem_rd_data;
            end else if (timeout_hit) begin
                data_q <= '0;
            end
        end
    end

    assign mem.mem_rd_req  = req_c;
    assign mem.mem_rd_addr = addr_q;
    assign rd_data_out     = data_q;
    assign rd_err          = err_q;
    assign stall_out       = (state != IDLE) | (rd_valid_in & rd_ready & op_legal);
endmodule
